block_packer: RTL and testbench
===============================

Name: block_packer

Overview:
- Parametrised successor to the FIFO-to-output stage in the UART→FIFO→SD path.
- Pulls bytes from the byte FIFO and groups them into fixed-length blocks for a block-oriented sink such as the SD writer.
- Pads partial blocks on flush request or idle timeout, optionally appends a CRC-8 trailer, and waits for a sink commit handshake.
- Keeps block and pad statistics for the seven-segment debug display.

Parameters:
- DATA_W, 8, byte width of FIFO/sink data.
- BLOCK_LEN, 512, payload bytes per block (≥2).
- TIMEOUT, 100000, idle cycles with FIFO empty before a partial block is padded out; 0 disables the timeout.
- PAD_BYTE, 8'h00, fill value.
- CRC_EN, 1, when 1, append one CRC-8 byte after the payload.
- CRC_POLY, 8'h07, CRC-8 polynomial; init 0x00, MSB-first, no reflection, no final XOR.

Ports:
- clk  in  1  single clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  permits FIFO reads and block start.
- flush  in  1  pulse; pad out the current partial block.
- fifo_empty  in  1  FIFO has no data.
- fifo_busy  in  1  FIFO cannot accept re this cycle.
- fifo_data  in  DATA_W  FIFO read data, valid the cycle after fifo_re.
- fifo_re  out  1  single-cycle read strobe.
- out_start  out  1  one-cycle pulse at block begin.
- out_valid  out  1  out_data valid.
- out_data  out  DATA_W  byte to sink.
- out_ready  in  1  sink accepts the byte when out_valid&&out_ready.
- out_finish  in  1  sink pulse: block committed.
- busy  out  1  high in any state other than IDLE.
- block_count  out  16  committed blocks; wraps 0xFFFF→0.
- pad_count  out  clog2(BLOCK_LEN+1)  pad bytes in the last committed block.
- crc  out  8  CRC of the last committed block.

Behaviour:
- Reset (reset_n low, asynchronous):
  - All outputs go to 0; FSM goes to IDLE; byte_idx, idle_cnt, running CRC and flush_pend are cleared.
  - An in-flight FIFO read is discarded; out_valid drops immediately.
- States: IDLE, WAIT_DATA, SEND, FETCH, PAD, CRC_TX, WAIT_FIN.
- IDLE:
  - Enters WAIT_DATA when enable && !fifo_empty && !fifo_busy.
  - In that same cycle: fifo_re=1, out_start=1, byte_idx=0, running CRC=0.
  - flush is ignored in IDLE, so no empty blocks are produced.
- WAIT_DATA: latch fifo_data into out_data; out_valid=1 next cycle; go to SEND.
- SEND:
  - Hold out_data and out_valid stable until out_ready.
  - On accept: update CRC, byte_idx++, out_valid=0, go to FETCH.
- FETCH decision, in priority order:
  1. byte_idx==BLOCK_LEN → CRC_TX if CRC_EN, else WAIT_FIN.
  2. flush_pend → PAD.
  3. enable && !fifo_empty && !fifo_busy → fifo_re=1, idle_cnt=0, go to WAIT_DATA.
  4. Otherwise idle_cnt++ (frozen while enable=0); when TIMEOUT≠0 and idle_cnt==TIMEOUT-1 → PAD.
- Steady-state throughput is 1 byte per 3 cycles with out_ready held high.
- flush handling:
  - Latched into flush_pend while in WAIT_DATA, SEND or FETCH; ignored in other states.
  - Cleared on entry to PAD, CRC_TX or IDLE.
  - A flush coinciding with the final payload byte is cleared and causes no padding.
  - An outstanding fifo_re completes and its byte is sent before padding starts.
  - FIFO contents remaining after a flush belong to the next block.
- PAD:
  - out_data=PAD_BYTE, out_valid=1.
  - Each accept updates CRC, byte_idx++ and increments the pad tally.
  - At byte_idx==BLOCK_LEN → CRC_TX or WAIT_FIN.
- CRC_TX: out_data=running CRC, out_valid=1; on accept → WAIT_FIN. The CRC covers payload plus pad bytes, not itself.
- WAIT_FIN:
  - out_valid=0; wait for out_finish.
  - On out_finish: block_count++, pad_count=tally, crc=final CRC, go to IDLE.
  - out_finish in any other state is ignored.
- enable low mid-block: the current byte completes; no new FIFO reads; padding, CRC transmit and the finish wait continue.

Decomposition:
- Package block_packer_pkg holds:
  - state encoding constants;
  - CRC_W=8;
  - the default CRC_POLY.
- Sub-module crc8_byte_step: combinational next-CRC from (crc_in, byte, poly), reusable by the CRC8 block.

Test Plan:
1. BLOCK_LEN=4, CRC_EN=1, push 01 02 03 04, out_ready=1 → out_start once; out_data 01,02,03,04 then the CRC byte matching the software model; after out_finish, block_count=1 and pad_count=0.
2. BLOCK_LEN=4, push 01, then flush → wire bytes 01,00,00,00,0x16; after out_finish, pad_count=3 and crc=0x16.
3. TIMEOUT=8, push AA only → exactly 8 empty FETCH cycles after the AA accept, then PAD starts; block is AA,00,00,00 plus CRC.
4. Backpressure: hold out_ready low 5 cycles during SEND of 0x5C → out_data=0x5C and out_valid=1 stable for all 5 cycles; no extra fifo_re.
5. reset_n low while byte_idx=2 → all outputs 0 asynchronously; after release, the next block starts from byte_idx 0 with block_count unchanged (0).
6. flush pulse in IDLE with FIFO empty, then push 7E → no out_start before the push; the resulting block carries 7E as its first byte, not a pad byte.

Source files
------------

// File: rtl/block_packer_pkg.sv
// rtl/block_packer_pkg.sv - shared types and constants for the block packer
package block_packer_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_DATA = 3'd1,
        S_SEND      = 3'd2,
        S_FETCH     = 3'd3,
        S_PAD       = 3'd4,
        S_CRC_TX    = 3'd5,
        S_WAIT_FIN  = 3'd6
    } state_t;

    localparam int             CRC_W            = 8;
    localparam logic [CRC_W-1:0] DEFAULT_CRC_POLY = 8'h07;

endpackage

// File: rtl/crc8_byte_step.sv
// rtl/crc8_byte_step.sv - combinational CRC-8 advance over one data word, MSB first
module crc8_byte_step
    import block_packer_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [CRC_W-1:0]  crc_in,
    input  logic [DATA_W-1:0] data,
    input  logic [CRC_W-1:0]  poly,
    output logic [CRC_W-1:0]  crc_out
);

    logic [CRC_W-1:0] c;
    logic             fb;

    always_comb begin
        c  = crc_in;
        fb = 1'b0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            fb = c[CRC_W-1] ^ data[i];
            c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? poly : {CRC_W{1'b0}});
        end
        crc_out = c;
    end

endmodule

// File: rtl/block_packer.sv
// rtl/block_packer.sv - groups FIFO bytes into fixed-length padded blocks with optional CRC-8 trailer
module block_packer
    import block_packer_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter int                BLOCK_LEN = 512,
    parameter int                TIMEOUT   = 100000,
    parameter logic [DATA_W-1:0] PAD_BYTE  = '0,
    parameter bit                CRC_EN    = 1'b1,
    parameter logic [CRC_W-1:0]  CRC_POLY  = DEFAULT_CRC_POLY,
    localparam int               IDX_W     = $clog2(BLOCK_LEN + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              flush,
    input  logic              fifo_empty,
    input  logic              fifo_busy,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_re,
    output logic              out_start,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    input  logic              out_finish,
    output logic              busy,
    output logic [15:0]       block_count,
    output logic [IDX_W-1:0]  pad_count,
    output logic [CRC_W-1:0]  crc
);

    localparam int IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t            state, state_next;
    logic [IDX_W-1:0]  byte_idx;
    logic [IDX_W-1:0]  pad_tally;
    logic [IDLE_W-1:0] idle_cnt;
    logic [CRC_W-1:0]  crc_run;
    logic [CRC_W-1:0]  crc_step;
    logic [DATA_W-1:0] data_reg;
    logic              flush_pend;
    logic              can_read;
    logic              read_c;
    logic              start_c;
    logic              accept;
    state_t            tail_state;

    assign can_read   = enable && !fifo_empty && !fifo_busy;
    assign tail_state = CRC_EN ? S_CRC_TX : S_WAIT_FIN;

    always_comb begin
        state_next = state;
        read_c     = 1'b0;
        start_c    = 1'b0;
        case (state)
            S_IDLE: begin
                if (can_read) begin
                    read_c     = 1'b1;
                    start_c    = 1'b1;
                    state_next = S_WAIT_DATA;
                end
            end
            S_WAIT_DATA: state_next = S_SEND;
            S_SEND: begin
                if (out_ready) state_next = S_FETCH;
            end
            S_FETCH: begin
                if (byte_idx == IDX_W'(BLOCK_LEN)) begin
                    state_next = tail_state;
                end else if (flush_pend) begin
                    state_next = S_PAD;
                end else if (can_read) begin
                    read_c     = 1'b1;
                    state_next = S_WAIT_DATA;
                end else if (TIMEOUT != 0 && idle_cnt == IDLE_W'(TIMEOUT - 1)) begin
                    state_next = S_PAD;
                end
            end
            S_PAD: begin
                if (out_ready && byte_idx == IDX_W'(BLOCK_LEN - 1)) state_next = tail_state;
            end
            S_CRC_TX: begin
                if (out_ready) state_next = S_WAIT_FIN;
            end
            S_WAIT_FIN: begin
                if (out_finish) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // The strobes are Mealy terms of IDLE; gating with reset_n keeps them low during reset.
    assign fifo_re   = read_c && reset_n;
    assign out_start = start_c && reset_n;
    assign out_valid = (state == S_SEND) || (state == S_PAD) || (state == S_CRC_TX);
    assign busy      = (state != S_IDLE);
    assign accept    = out_valid && out_ready;

    always_comb begin
        out_data = '0;
        case (state)
            S_SEND:   out_data = data_reg;
            S_PAD:    out_data = PAD_BYTE;
            S_CRC_TX: out_data = DATA_W'(crc_run);
            default:  out_data = '0;
        endcase
    end

    crc8_byte_step #(
        .DATA_W (DATA_W)
    ) u_crc_step (
        .crc_in  (crc_run),
        .data    (out_data),
        .poly    (CRC_POLY),
        .crc_out (crc_step)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            byte_idx    <= '0;
            pad_tally   <= '0;
            idle_cnt    <= '0;
            crc_run     <= '0;
            data_reg    <= '0;
            flush_pend  <= 1'b0;
            block_count <= '0;
            pad_count   <= '0;
            crc         <= '0;
        end else begin
            state <= state_next;

            if (state == S_WAIT_DATA) data_reg <= fifo_data;

            if (start_c) begin
                byte_idx  <= '0;
                pad_tally <= '0;
                crc_run   <= '0;
            end else if (accept && state != S_CRC_TX) begin
                crc_run  <= crc_step;
                byte_idx <= byte_idx + 1'b1;
                if (state == S_PAD) pad_tally <= pad_tally + 1'b1;
            end

            // Counts only consecutive starved FETCH cycles; frozen while enable is low.
            if (state == S_FETCH && state_next == S_FETCH) begin
                if (enable) idle_cnt <= idle_cnt + 1'b1;
            end else begin
                idle_cnt <= '0;
            end

            if (state_next == S_PAD || state_next == S_CRC_TX || state_next == S_IDLE) begin
                flush_pend <= 1'b0;
            end else if (flush && (state == S_WAIT_DATA || state == S_SEND || state == S_FETCH)) begin
                flush_pend <= 1'b1;
            end

            if (state == S_WAIT_FIN && out_finish) begin
                block_count <= block_count + 16'd1;
                pad_count   <= pad_tally;
                crc         <= crc_run;
            end
        end
    end

endmodule

// File: tb/tb_block_packer.sv
// tb/tb_block_packer.sv - self-checking bench for block_packer with FIFO model and wire-byte scoreboard
module tb_block_packer;

    localparam int BLOCK_LEN = 4;
    localparam int TIMEOUT   = 8;
    localparam int PW        = $clog2(BLOCK_LEN + 1);

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b0;
    logic          flush = 1'b0;
    logic          fifo_empty = 1'b1;
    logic          fifo_busy = 1'b0;
    logic [7:0]    fifo_data = 8'h00;
    logic          fifo_re;
    logic          out_start;
    logic          out_valid;
    logic [7:0]    out_data;
    logic          out_ready = 1'b1;
    logic          out_finish = 1'b0;
    logic          busy;
    logic [15:0]   block_count;
    logic [PW-1:0] pad_count;
    logic [7:0]    crc;

    block_packer #(
        .DATA_W    (8),
        .BLOCK_LEN (BLOCK_LEN),
        .TIMEOUT   (TIMEOUT),
        .PAD_BYTE  (8'h00),
        .CRC_EN    (1'b1),
        .CRC_POLY  (8'h07)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .flush       (flush),
        .fifo_empty  (fifo_empty),
        .fifo_busy   (fifo_busy),
        .fifo_data   (fifo_data),
        .fifo_re     (fifo_re),
        .out_start   (out_start),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .out_finish  (out_finish),
        .busy        (busy),
        .block_count (block_count),
        .pad_count   (pad_count),
        .crc         (crc)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         n;
        logic [7:0] b [4];
        int         mode;   // 0 none, 1 flush after last read, 2 flush on final payload byte
        int         pad;
    } vec_t;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] fifo_q [$];
    logic [7:0] exp_q [$];
    int         acc_cyc [$];
    int         cyc = 0;
    int         re_cnt = 0;
    int         start_cnt = 0;
    int         exp_blocks = 0;
    bit         re_pend = 1'b0;
    logic [7:0] re_byte = 8'h00;
    vec_t       vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    function automatic logic [7:0] crc_model(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int i = 0; i < 8; i++) r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
        return r;
    endfunction

    function automatic vec_t mk(input int n, input logic [7:0] b0, input logic [7:0] b1,
                                input logic [7:0] b2, input logic [7:0] b3, input int mode, input int pad);
        vec_t v;
        v.n = n; v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3;
        v.mode = mode; v.pad = pad;
        return v;
    endfunction

    // Called at a falling edge with inputs set; samples what the next rising edge will commit.
    task automatic tick();
        #1;
        if (fifo_re) begin
            re_cnt++;
            re_byte = (fifo_q.size() > 0) ? fifo_q.pop_front() : 8'h00;
            re_pend = 1'b1;
        end
        if (out_start) start_cnt++;
        if (out_valid && out_ready) begin
            acc_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL wire_unexpected: got %0h required none", out_data);
            end else begin
                check("wire_byte", {24'h0, out_data}, {24'h0, exp_q.pop_front()});
            end
        end
        @(negedge clk);
        cyc++;
        if (re_pend) begin
            fifo_data = re_byte;
            re_pend   = 1'b0;
        end
        fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic push_bytes(input vec_t v);
        for (int i = 0; i < v.n; i++) fifo_q.push_back(v.b[i]);
        fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic add_expect(input vec_t v, output logic [7:0] c);
        logic [7:0] x;
        c = 8'h00;
        for (int i = 0; i < BLOCK_LEN; i++) begin
            x = (i < v.n) ? v.b[i] : 8'h00;
            exp_q.push_back(x);
            c = crc_model(c, x);
        end
        exp_q.push_back(c);
    endtask

    task automatic wait_drain(input string name);
        int t = 0;
        while (exp_q.size() > 0 && t < 200) begin
            tick();
            t++;
        end
        check({name, "_drain"}, exp_q.size(), 0);
    endtask

    task automatic finish_block(input string name, input int pad, input logic [7:0] c);
        tick();
        check({name, "_finbusy"}, {31'h0, busy}, 1);
        check({name, "_finvalid"}, {31'h0, out_valid}, 0);
        out_finish = 1'b1;
        tick();
        out_finish = 1'b0;
        exp_blocks++;
        check({name, "_count"}, {16'h0, block_count}, exp_blocks);
        check({name, "_pad"}, pad_count, pad);
        check({name, "_crc"}, {24'h0, crc}, {24'h0, c});
        check({name, "_idle"}, {31'h0, busy}, 0);
    endtask

    initial begin
        logic [7:0] c;
        int         s0;
        int         r0;
        int         t;
        vec_t       v;

        vecs[0] = mk(4, 8'h01, 8'h02, 8'h03, 8'h04, 0, 0);
        vecs[1] = mk(1, 8'h01, 8'h00, 8'h00, 8'h00, 1, 3);
        vecs[2] = mk(2, 8'hA5, 8'h5A, 8'h00, 8'h00, 1, 2);
        vecs[3] = mk(3, 8'hFF, 8'hFF, 8'hFF, 8'h00, 1, 1);
        vecs[4] = mk(4, 8'h10, 8'h20, 8'h30, 8'h40, 2, 0);

        @(negedge clk);
        #1;
        check("rst_valid", {31'h0, out_valid}, 0);
        check("rst_busy", {31'h0, busy}, 0);
        check("rst_count", {16'h0, block_count}, 0);
        check("rst_crc", {24'h0, crc}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        enable  = 1'b1;
        tick();

        for (int r = 0; r < 5; r++) begin
            s0 = start_cnt;
            acc_cyc.delete();
            add_expect(vecs[r], c);
            push_bytes(vecs[r]);
            if (vecs[r].mode == 1) begin
                t = 0;
                while (fifo_q.size() > 0 && t < 50) begin tick(); t++; end
                check("flush_sync", fifo_q.size(), 0);
                flush = 1'b1; tick(); flush = 1'b0;
            end else if (vecs[r].mode == 2) begin
                t = 0;
                while (!(exp_q.size() == 2 && out_valid) && t < 50) begin tick(); t++; end
                check("final_flush_sync", exp_q.size(), 2);
                flush = 1'b1; tick(); flush = 1'b0;
            end
            wait_drain("vec");
            if (r == 0) check("throughput", acc_cyc[1] - acc_cyc[0], 3);
            finish_block("vec", vecs[r].pad, c);
            check("vec_starts", start_cnt - s0, 1);
            if (r == 1) check("crc_0x16", {24'h0, crc}, 32'h16);
        end

        // Idle timeout: exactly TIMEOUT starved FETCH cycles before the first pad byte.
        v = mk(1, 8'hAA, 8'h00, 8'h00, 8'h00, 0, 3);
        acc_cyc.delete();
        add_expect(v, c);
        push_bytes(v);
        wait_drain("timeout");
        check("timeout_gap", acc_cyc[1] - acc_cyc[0] - 1, TIMEOUT);
        finish_block("timeout", 3, c);

        // Backpressure: byte held stable, no extra FIFO reads.
        out_ready = 1'b0;
        r0 = re_cnt;
        v = mk(1, 8'h5C, 8'h00, 8'h00, 8'h00, 0, 3);
        add_expect(v, c);
        push_bytes(v);
        t = 0;
        while (!out_valid && t < 20) begin tick(); t++; end
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", {31'h0, out_valid}, 1);
            check("bp_data", {24'h0, out_data}, 32'h5C);
            tick();
        end
        check("bp_reads", re_cnt - r0, 1);
        out_ready = 1'b1;
        wait_drain("bp");
        finish_block("bp", 3, c);

        // Asynchronous reset mid-block.
        v = mk(4, 8'h21, 8'h22, 8'h23, 8'h24, 0, 0);
        add_expect(v, c);
        push_bytes(v);
        t = 0;
        while (exp_q.size() > 3 && t < 50) begin tick(); t++; end
        reset_n = 1'b0;
        #1;
        check("arst_valid", {31'h0, out_valid}, 0);
        check("arst_data", {24'h0, out_data}, 0);
        check("arst_re", {31'h0, fifo_re}, 0);
        check("arst_start", {31'h0, out_start}, 0);
        check("arst_busy", {31'h0, busy}, 0);
        check("arst_count", {16'h0, block_count}, 0);
        check("arst_pad", pad_count, 0);
        check("arst_crc", {24'h0, crc}, 0);
        fifo_q.delete();
        exp_q.delete();
        re_pend    = 1'b0;
        fifo_empty = 1'b1;
        exp_blocks = 0;
        @(negedge clk);
        tick();
        reset_n = 1'b1;
        tick();
        v = mk(4, 8'h31, 8'h32, 8'h33, 8'h34, 0, 0);
        add_expect(v, c);
        push_bytes(v);
        wait_drain("post_rst");
        finish_block("post_rst", 0, c);

        // Flush in IDLE is ignored; the following byte starts a fresh block.
        flush = 1'b1; tick(); flush = 1'b0;
        s0 = start_cnt;
        repeat (5) tick();
        check("idle_flush_start", start_cnt - s0, 0);
        check("idle_flush_busy", {31'h0, busy}, 0);
        v = mk(1, 8'h7E, 8'h00, 8'h00, 8'h00, 0, 3);
        add_expect(v, c);
        push_bytes(v);
        wait_drain("idle_flush");
        finish_block("idle_flush", 3, c);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
